// File: rtl/game_flow_ctrl_if.sv
// Bundle of gameplay inputs and status outputs between the game sequencer and
// the sprite/collision logic and screen mappers. The sequencer takes the slave
// modport; its environment takes master.
interface game_flow_ctrl_if;
  logic       frame_clk;
  logic       start_key;
  logic       point_evt;
  logic       hit_evt;
  logic       pause_key;
  logic [1:0] screen_sel;
  logic       is_won;
  logic       is_lost;
  logic [6:0] score;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [1:0] lives;
  logic       game_active;
  logic       paused;

  modport master (
    output frame_clk, start_key, point_evt, hit_evt, pause_key,
    input  screen_sel, is_won, is_lost, score, score_tens, score_ones, lives,
           game_active, paused
  );

  modport slave (
    input  frame_clk, start_key, point_evt, hit_evt, pause_key,
    output screen_sel, is_won, is_lost, score, score_tens, score_ones, lives,
           game_active, paused
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game sequencer: title / play / won / lost states, score (binary + BCD),
// lives, end-screen hold timer and screen-select for the VGA mux.
// Optional pause support is built when the macro PAUSE_EN is defined.
module game_flow_ctrl #(
  parameter int unsigned WIN_SCORE       = 20,
  parameter int unsigned START_LIVES     = 3,
  parameter int unsigned MAX_SCORE       = 99,
  parameter int unsigned END_HOLD_FRAMES = 300
) (
  input logic             Clk,
  input logic             Reset,
  game_flow_ctrl_if.slave bus
);

  localparam int unsigned HoldW = (END_HOLD_FRAMES > 2) ? $clog2(END_HOLD_FRAMES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(END_HOLD_FRAMES - 1);
  localparam logic [6:0] WinScore  = 7'(WIN_SCORE);
  localparam logic [6:0] MaxScore  = 7'(MAX_SCORE);
  localparam logic [1:0] LoadLives = 2'(START_LIVES);

  typedef enum logic [2:0] {
    StTitle,
    StPlay,
    StWon,
    StLost
`ifdef PAUSE_EN
    , StPaused
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       score_q, score_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [1:0]       lives_q, lives_d;
  logic [HoldW-1:0] hold_q, hold_d;

  // Previous levels plus an arm bit per input: a level that is already high
  // when reset releases must drop once before it may produce an edge.
  logic       start_prev_q, frame_prev_q, pause_prev_q;
  logic [2:0] arm_q;
  logic       start_edge, frame_edge, pause_edge;

  logic [1:0] screen_sel_q, screen_sel_d;
  logic       is_won_q, is_won_d;
  logic       is_lost_q, is_lost_d;
  logic       active_q, active_d;
  logic       paused_q, paused_d;

  assign start_edge = bus.start_key & ~start_prev_q & arm_q[0];
  assign frame_edge = bus.frame_clk & ~frame_prev_q & arm_q[1];
  assign pause_edge = bus.pause_key & ~pause_prev_q & arm_q[2];

`ifndef PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_edge;
`endif

  // Next-state, score, lives and hold-timer update.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    lives_d = lives_q;
    hold_d  = hold_q;
    case (state_q)
      StTitle: begin
        if (start_edge) begin
          state_d = StPlay;
          score_d = 7'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          lives_d = LoadLives;
          hold_d  = '0;
        end
      end
      StPlay: begin
        if (bus.point_evt && (score_q < MaxScore)) begin
          score_d = score_q + 7'd1;
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
        if (bus.hit_evt && (lives_q != 2'd0)) begin
          lives_d = lives_q - 2'd1;
        end
        // Decided on post-update values; loss wins over a simultaneous win.
        if (lives_d == 2'd0) begin
          state_d = StLost;
        end else if (score_d >= WinScore) begin
          state_d = StWon;
        end
`ifdef PAUSE_EN
        else if (pause_edge) begin
          state_d = StPaused;
        end
`endif
      end
      StWon, StLost: begin
        if (start_edge) begin
          state_d = StTitle;
          hold_d  = '0;
        end else if (frame_edge) begin
          if (hold_q == HoldLast) begin
            state_d = StTitle;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end
`ifdef PAUSE_EN
      StPaused: begin
        if (pause_edge) begin
          state_d = StPlay;
        end
      end
`endif
      default: state_d = StTitle;
    endcase
  end

  // Output decode from the next state so the registered outputs track state.
  always_comb begin
    screen_sel_d = 2'd0;
    is_won_d     = 1'b0;
    is_lost_d    = 1'b0;
    active_d     = 1'b0;
    paused_d     = 1'b0;
    case (state_d)
      StPlay:  begin screen_sel_d = 2'd1; active_d = 1'b1; end
      StWon:   begin screen_sel_d = 2'd2; is_won_d = 1'b1; end
      StLost:  begin screen_sel_d = 2'd2; is_lost_d = 1'b1; end
`ifdef PAUSE_EN
      StPaused: begin screen_sel_d = 2'd1; paused_d = 1'b1; end
`endif
      default: screen_sel_d = 2'd0;
    endcase
  end

  // State, datapath, edge detectors and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StTitle;
      score_q      <= 7'd0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      lives_q      <= 2'd0;
      hold_q       <= '0;
      start_prev_q <= 1'b0;
      frame_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      arm_q        <= 3'b000;
      screen_sel_q <= 2'd0;
      is_won_q     <= 1'b0;
      is_lost_q    <= 1'b0;
      active_q     <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      lives_q      <= lives_d;
      hold_q       <= hold_d;
      start_prev_q <= bus.start_key;
      frame_prev_q <= bus.frame_clk;
      pause_prev_q <= bus.pause_key;
      arm_q        <= arm_q | ~{bus.pause_key, bus.frame_clk, bus.start_key};
      screen_sel_q <= screen_sel_d;
      is_won_q     <= is_won_d;
      is_lost_q    <= is_lost_d;
      active_q     <= active_d;
      paused_q     <= paused_d;
    end
  end

  assign bus.screen_sel  = screen_sel_q;
  assign bus.is_won      = is_won_q;
  assign bus.is_lost     = is_lost_q;
  assign bus.score       = score_q;
  assign bus.score_tens  = tens_q;
  assign bus.score_ones  = ones_q;
  assign bus.lives       = lives_q;
  assign bus.game_active = active_q;
  assign bus.paused      = paused_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: each stimulus cycle pushes its expected
// outputs, which are popped and compared one cycle later.
module tb_game_flow_ctrl;

  logic Clk;
  logic Reset;

  game_flow_ctrl_if bus ();

  game_flow_ctrl #(
    .WIN_SCORE      (12),
    .START_LIVES    (2),
    .MAX_SCORE      (12),
    .END_HOLD_FRAMES(4)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0] sel;
    logic       won;
    logic       lost;
    int         score;
    int         lives;
    logic       act;
    logic       pau;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef PAUSE_EN
  localparam bit PauseOn = 1'b1;
`else
  localparam bit PauseOn = 1'b0;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] sel, input logic won, input logic lost,
                              input int score, input int lives, input logic act,
                              input logic pau);
    exp_t e;
    e.sel = sel; e.won = won; e.lost = lost; e.score = score;
    e.lives = lives; e.act = act; e.pau = pau;
    return e;
  endfunction

  function automatic exp_t title(input int s, input int l);
    return mk(2'd0, 1'b0, 1'b0, s, l, 1'b0, 1'b0);
  endfunction
  function automatic exp_t play(input int s, input int l);
    return mk(2'd1, 1'b0, 1'b0, s, l, 1'b1, 1'b0);
  endfunction
  function automatic exp_t won(input int s, input int l);
    return mk(2'd2, 1'b1, 1'b0, s, l, 1'b0, 1'b0);
  endfunction
  function automatic exp_t lost(input int s, input int l);
    return mk(2'd2, 1'b0, 1'b1, s, l, 1'b0, 1'b0);
  endfunction
  function automatic exp_t pausd(input int s, input int l);
    return mk(2'd1, 1'b0, 1'b0, s, l, 1'b0, 1'b1);
  endfunction

  // Pop the oldest expectation and compare every output against it.
  task automatic compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".sel"},   32'(bus.screen_sel),  32'(e.sel));
    check({tag, ".won"},   32'(bus.is_won),      32'(e.won));
    check({tag, ".lost"},  32'(bus.is_lost),     32'(e.lost));
    check({tag, ".score"}, 32'(bus.score),       32'(e.score));
    check({tag, ".tens"},  32'(bus.score_tens),  32'(e.score / 10));
    check({tag, ".ones"},  32'(bus.score_ones),  32'(e.score % 10));
    check({tag, ".lives"}, 32'(bus.lives),       32'(e.lives));
    check({tag, ".act"},   32'(bus.game_active), 32'(e.act));
    check({tag, ".pau"},   32'(bus.paused),      32'(e.pau));
  endtask

  // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic st, input logic pt, input logic ht, input logic fr,
                      input logic pa, input exp_t e, input string tag);
    bus.start_key = st;
    bus.point_evt = pt;
    bus.hit_evt   = ht;
    bus.frame_clk = fr;
    bus.pause_key = pa;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    compare(tag);
  endtask

  task automatic idle(input exp_t e, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, tag);
  endtask

  initial begin
    Reset = 1'b1;
    bus.start_key = 1'b1;
    bus.point_evt = 1'b0;
    bus.hit_evt   = 1'b0;
    bus.frame_clk = 1'b0;
    bus.pause_key = 1'b0;

    // Reset state, with start held through reset.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, title(0, 0), "rst");
    Reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, title(0, 0), "held_start");
    idle(title(0, 0), "release");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, play(0, 2), "start");
    idle(play(0, 2), "play_idle");
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, play(i, 2), "pt5");

    // Asynchronous reset mid-game takes effect before any clock edge.
    Reset = 1'b1;
    #1;
    sb_q.push_back(title(0, 0));
    compare("async_rst");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle(title(0, 0), "post_rst");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, play(0, 2), "restart");
    idle(play(0, 2), "restart_idle");

    // Count to the win score through the BCD carry.
    for (int i = 1; i <= 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, play(i, 2), "count");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, won(12, 2), "win");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, won(12, 2), "won_pt_ignored");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, won(12, 2), "won_hit_ignored");

    // End-screen hold: three ticks stay, the fourth returns to title.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, won(12, 2), "hold_tick");
      idle(won(12, 2), "hold_gap");
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, title(12, 2), "hold_exit");
    idle(title(12, 2), "title_keeps_score");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, play(0, 2), "replay_clears");
    idle(play(0, 2), "replay_idle");

    // Simultaneous point and hit on the last life: loss beats win.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, play(0, 1), "hit");
    for (int i = 1; i <= 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, play(i, 1), "count2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, lost(12, 0), "loss_prio");
    idle(lost(12, 0), "lost_idle");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, title(12, 0), "lost_start_exit");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, title(12, 0), "no_double_start");
    idle(title(12, 0), "title_idle");

    // Start is ignored during play.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, play(0, 2), "start3");
    idle(play(0, 2), "play3");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, play(0, 2), "start_ignored");
    idle(play(0, 2), "play3b");

    // Pause behaviour depends on the build.
    if (PauseOn) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pausd(0, 2), "pause_on");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pausd(0, 2), "pause_pt");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, pausd(0, 2), "pause_start_hit");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, play(0, 2), "pause_off");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, play(1, 2), "resume_pt");
    end else begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, play(0, 2), "nopause_key");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, play(1, 2), "nopause_pt");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, play(1, 1), "nopause_hit");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, play(1, 1), "nopause_key2");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, play(2, 1), "nopause_pt2");
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer: owns game state (title, play, won, lost), score and lives.
- Drives the screen-select mux that picks the title, play-field or end-screen color mapper for VGA output.
- Supplies is_won/is_lost and score to the end-screen mapper.
- Consumes one-cycle gameplay event pulses from the sprite/collision logic and the per-frame tick.

Parameters:
WIN_SCORE, 20, score at which PLAY -> WON
START_LIVES, 3, lives loaded on entry to PLAY (1..3)
MAX_SCORE, 99, score saturation ceiling (>= WIN_SCORE)
END_HOLD_FRAMES, 300, frame ticks the end screen is held before auto-return to TITLE

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
frame_clk  input  1  VGA vsync-derived level, synchronous to Clk; rising edge = one frame tick
start_key  input  1  start/confirm key level; rising edge acts
point_evt  input  1  one-Clk pulse, player scored one point
hit_evt  input  1  one-Clk pulse, player lost one life
pause_key  input  1  pause key level (used only with PAUSE_EN)
screen_sel  output  2  0=title, 1=play, 2=end, 3 unused
is_won  output  1  state==WON
is_lost  output  1  state==LOST
score  output  7  binary score, 0..MAX_SCORE
score_tens  output  4  BCD tens digit of score
score_ones  output  4  BCD ones digit of score
lives  output  2  remaining lives
game_active  output  1  state==PLAY (enables sprite motion)
paused  output  1  pause indicator

Behaviour:
- Reset (async assert, sync release): state=TITLE; score=0; tens=0; ones=0; lives=0; hold counter=0; edge-detect registers=0. Outputs: screen_sel=0, is_won=0, is_lost=0, game_active=0, paused=0.
- Outputs are registered or decoded from registered state. They change on the Clk edge that samples the event (1-cycle latency).
- Edge detection: start, frame and pause edges = current level & ~previous registered level. A key held through reset produces no edge until released and re-pressed.
- TITLE: on start edge -> PLAY; same edge loads score=0, BCD=0/0, lives=START_LIVES, hold=0.
- PLAY:
  - point_evt increments score, saturating at MAX_SCORE. BCD digits are maintained incrementally: ones 9 -> 0 with tens+1. Binary and BCD update on the same edge and are always consistent.
  - hit_evt decrements lives; never underflows below 0.
  - Next state evaluated on post-update values: lives==0 -> LOST; else score>=WIN_SCORE -> WON.
  - Simultaneous point_evt and hit_evt: both applied. Loss has priority if both conditions are met.
  - start_key ignored.
- WON / LOST:
  - Score and lives frozen. point_evt and hit_evt ignored.
  - Each frame tick increments hold. When hold reaches END_HOLD_FRAMES-1 and a tick occurs -> TITLE.
  - A start edge -> TITLE immediately; this edge does not also start a new game.
  - Score is retained through TITLE until the next PLAY entry.
- screen_sel: TITLE=0, PLAY/PAUSED=1, WON/LOST=2.
- Events arriving in the same cycle as a state transition are applied only if the current state is PLAY.
- Reset mid-game forces TITLE regardless of state or pending events.

Optional Feature:
- Macro PAUSE_EN.
- Defined: extra state PAUSED.
  - pause edge in PLAY -> PAUSED; pause edge in PAUSED -> PLAY.
  - In PAUSED: point_evt/hit_evt ignored, game_active=0, paused=1, screen_sel=1.
  - start edge in PAUSED is ignored.
- Undefined: pause_key is ignored, paused tied 0, no PAUSED state.

Test Plan:
1. Assert Reset mid-PLAY with score=5 -> same cycle: screen_sel=0, score=0, lives=0, game_active=0; after release, a start edge gives lives=3, screen_sel=1.
2. WIN_SCORE=3: start, then 3 point_evt pulses -> score 1,2,3; state WON on the 3rd pulse's edge with is_won=1, screen_sel=2; score_tens=0, score_ones=3.
3. Start, then 12 point_evt pulses -> score=12, tens=1, ones=2. With MAX_SCORE=12, a 13th pulse keeps score=12.
4. START_LIVES=1, WIN_SCORE=3, score=2: point_evt and hit_evt in the same cycle -> score=3, lives=0, state LOST (is_lost=1, is_won=0).
5. END_HOLD_FRAMES=4 in WON: 3 frame ticks -> still WON; 4th tick -> TITLE; score remains displayed until the next start edge clears it to 0.
6. PAUSE_EN: in PLAY, pause edge -> paused=1, game_active=0; point_evt ignored (score unchanged); second pause edge -> PLAY. Without PAUSE_EN the same stimulus leaves paused=0 and score increments.
